// File: rtl/adc_lvds_tx_emu.sv
// adc_lvds_tx_emu
// Emulates the quad ADC's 2-lane-per-channel serial LVDS output, one bit per
// lane per clock. A 16-bit word {sample, 2'b00} is sent MSB first: d1 carries
// the odd bit positions and d0 the even ones, so a frame lasts 8 clocks.
// Samples come from a ramp, a fixed word, a checkerboard or an external
// stream. A commanded slip inserts one idle bit before the next frame.
module adc_lvds_tx_emu #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned SAMPLE_W = 14
) (
   input  logic                       clk_200m,
   input  logic                       rst_200m,
   input  logic                       en,
   input  logic [1:0]                 pattern_sel,
   input  logic [SAMPLE_W-1:0]        pattern_reg,
   input  logic [NUM_CH*SAMPLE_W-1:0] ext_data,
   input  logic                       ext_valid,
   output logic                       ext_ready,
   input  logic                       slip_req,
   output logic                       fclk,
   output logic [NUM_CH-1:0]          d1,
   output logic [NUM_CH-1:0]          d0,
   output logic                       frame_start,
   output logic                       underrun
);

   localparam int unsigned WORD_W     = SAMPLE_W + 2;
   localparam int unsigned FRAME_BITS = WORD_W / 2;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

   localparam logic [1:0] SEL_RAMP  = 2'd0;
   localparam logic [1:0] SEL_FIXED = 2'd1;
   localparam logic [1:0] SEL_CHK   = 2'd2;

   // 0x2AAA / 0x1555 for a 14-bit sample
   localparam logic [SAMPLE_W-1:0] CHK_A = {(SAMPLE_W/2){2'b10}};
   localparam logic [SAMPLE_W-1:0] CHK_B = ~CHK_A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CNT_W-1:0]           r_bit_cnt;
   logic                       r_slip_pending;
   logic [SAMPLE_W-1:0]        r_ramp;
   logic                       r_chk_phase;
   logic [NUM_CH*SAMPLE_W-1:0] r_ext;
   logic [WORD_W-1:0]          r_shift [NUM_CH];

   logic                       w_load;
   logic                       w_last_bit;
   logic                       w_slip;
   logic                       w_ext_load;
   logic [SAMPLE_W-1:0]        w_sample [NUM_CH];

   assign w_last_bit = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
   // A slip request landing in the last bit cycle still applies to this boundary
   assign w_slip     = r_slip_pending | slip_req;
   assign w_ext_load = w_load & (pattern_sel == 2'd3);

   // State register
   always_ff @(posedge clk_200m or posedge rst_200m) begin
      if (rst_200m) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and load-point decision
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (w_last_bit) begin
               if (w_slip) begin
                  w_state_nxt = ST_GAP;
               end else if (en) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (en) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SEND;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sample set selected for the next load point
   always_comb begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         w_sample[k] = '0;
         case (pattern_sel)
            SEL_RAMP:  w_sample[k] = r_ramp + SAMPLE_W'(k);
            SEL_FIXED: w_sample[k] = pattern_reg;
            SEL_CHK:   w_sample[k] = r_chk_phase ? CHK_B : CHK_A;
            default: begin
               // Underrun repeats the previously accepted set
               w_sample[k] = ext_valid ? ext_data[k*SAMPLE_W +: SAMPLE_W]
                                       : r_ext[k*SAMPLE_W +: SAMPLE_W];
            end
         endcase
      end
   end

   // Serializer: the load cycle drives bit 0 directly and parks the rest
   // of the word in the shift register, so frames run back to back
   always_ff @(posedge clk_200m or posedge rst_200m) begin
      if (rst_200m) begin
         r_bit_cnt   <= '0;
         fclk        <= 1'b0;
         d1          <= '0;
         d0          <= '0;
         frame_start <= 1'b0;
         ext_ready   <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            r_shift[k] <= '0;
         end
      end else begin
         frame_start <= w_load;
         ext_ready   <= w_ext_load & ext_valid;
         if (w_load) begin
            r_bit_cnt <= '0;
            fclk      <= 1'b1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               d1[k]      <= w_sample[k][SAMPLE_W-1];
               d0[k]      <= w_sample[k][SAMPLE_W-2];
               r_shift[k] <= {w_sample[k][SAMPLE_W-3:0], 4'b0000};
            end
         end else if ((r_state == ST_SEND) && !w_last_bit) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            // Bit n+1 is on the lanes next; fclk high for the first half
            fclk      <= (r_bit_cnt < CNT_W'(FRAME_BITS/2 - 1));
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               d1[k]      <= r_shift[k][WORD_W-1];
               d0[k]      <= r_shift[k][WORD_W-2];
               r_shift[k] <= {r_shift[k][WORD_W-3:0], 2'b00};
            end
         end else begin
            r_bit_cnt <= '0;
            fclk      <= 1'b0;
            d1        <= '0;
            d0        <= '0;
         end
      end
   end

   // Pattern generators, slip request latch and sticky underrun flag
   always_ff @(posedge clk_200m or posedge rst_200m) begin
      if (rst_200m) begin
         r_slip_pending <= 1'b0;
         r_ramp         <= '0;
         r_chk_phase    <= 1'b0;
         r_ext          <= '0;
         underrun       <= 1'b0;
      end else begin
         r_slip_pending <= slip_req | (r_slip_pending & (r_state != ST_GAP));
         if (w_load && (pattern_sel == SEL_RAMP)) begin
            r_ramp <= r_ramp + SAMPLE_W'(1);
         end
         if (r_state == ST_IDLE) begin
            r_chk_phase <= 1'b0;
         end else if (w_load && (pattern_sel == SEL_CHK)) begin
            r_chk_phase <= ~r_chk_phase;
         end
         if (w_ext_load) begin
            if (ext_valid) begin
               r_ext <= ext_data;
            end else begin
               underrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_lvds_tx_emu.sv
// Scoreboard bench for adc_lvds_tx_emu: the driver pushes the expected
// sample set, ext_ready value and frame period for every frame it arranges;
// the monitor pops one entry per frame_start and rebuilds the words from
// the lanes.
module tb_adc_lvds_tx_emu;

   typedef struct packed {
      logic [55:0] words;
      logic        rdy;
      logic [7:0]  period;
   } exp_t;

   logic        clk_200m;
   logic        rst_200m;
   logic        en;
   logic [1:0]  pattern_sel;
   logic [13:0] pattern_reg;
   logic [55:0] ext_data;
   logic        ext_valid;
   logic        ext_ready;
   logic        slip_req;
   logic        fclk;
   logic [3:0]  d1;
   logic [3:0]  d0;
   logic        frame_start;
   logic        underrun;

   int   n_checks;
   int   n_errors;
   exp_t q[$];

   adc_lvds_tx_emu #(
      .NUM_CH   (4),
      .SAMPLE_W (14)
   ) dut (
      .clk_200m    (clk_200m),
      .rst_200m    (rst_200m),
      .en          (en),
      .pattern_sel (pattern_sel),
      .pattern_reg (pattern_reg),
      .ext_data    (ext_data),
      .ext_valid   (ext_valid),
      .ext_ready   (ext_ready),
      .slip_req    (slip_req),
      .fclk        (fclk),
      .d1          (d1),
      .d0          (d0),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   initial clk_200m = 1'b0;
   always #5 clk_200m = ~clk_200m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [55:0] same4(input logic [13:0] v);
      return {v, v, v, v};
   endfunction

   function automatic logic [55:0] ramp4(input logic [13:0] base);
      logic [13:0] c [4];
      for (int k = 0; k < 4; k++) c[k] = base + 14'(k);
      return {c[3], c[2], c[1], c[0]};
   endfunction

   task automatic push(input logic [55:0] w, input logic rdy, input int period);
      exp_t e;
      e.words  = w;
      e.rdy    = rdy;
      e.period = 8'(period);
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_200m);
      #1;
   endtask

   task automatic wait_fs(input string name);
      int t;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (!frame_start && t < 40);
      if (!frame_start) chk({name, "_timeout"}, 64'(frame_start), 64'd1);
   endtask

   // Monitor: frame framing, fclk shape, idle/gap zeros, words, ext_ready, period
   initial begin
      int          bitn;
      int          since;
      exp_t        cur;
      logic [15:0] acc [4];
      bitn = 8;
      since = 0;
      cur = '0;
      for (int k = 0; k < 4; k++) acc[k] = '0;
      forever begin
         @(negedge clk_200m);
         if (rst_200m) begin
            bitn = 8;
            since = 0;
            continue;
         end
         since++;
         if (frame_start) begin
            chk("frame_len", 64'(bitn), 64'd8);
            if (q.size() == 0) begin
               chk("unexpected_frame", 64'd1, 64'd0);
               cur = '0;
            end else begin
               cur = q.pop_front();
            end
            chk("ext_ready_at_load", 64'(ext_ready), 64'(cur.rdy));
            if (cur.period != 0) chk("frame_period", 64'(since), 64'(cur.period));
            since = 0;
            bitn = 0;
         end else begin
            chk("ext_ready_quiet", 64'(ext_ready), 64'd0);
         end
         if (bitn < 8) begin
            chk("fclk_shape", 64'(fclk), 64'(bitn < 4));
            for (int k = 0; k < 4; k++) acc[k] = {acc[k][13:0], d1[k], d0[k]};
            bitn++;
            if (bitn == 8) begin
               for (int k = 0; k < 4; k++)
                  chk($sformatf("word_ch%0d", k), 64'(acc[k]), 64'({cur.words[k*14 +: 14], 2'b00}));
            end
         end else begin
            chk("idle_lanes", 64'({fclk, d1, d0}), 64'd0);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   // Driver
   initial begin
      logic [7:0]  d1t;
      logic [7:0]  d0t;
      logic [55:0] ext_a;
      logic [55:0] ext_b;
      logic [55:0] ext_c;
      n_checks    = 0;
      n_errors    = 0;
      d1t         = 8'b1111_1100;
      d0t         = 8'b0000_1100;
      ext_a       = {14'h0000, 14'h3FFF, 14'h1ABC, 14'h0123};
      ext_b       = {14'h1111, 14'h2222, 14'h3333, 14'h0444};
      ext_c       = {14'h0F0F, 14'h30C3, 14'h0001, 14'h2DB6};
      rst_200m    = 1'b1;
      en          = 1'b0;
      pattern_sel = 2'd1;
      pattern_reg = 14'h2ABC;
      ext_data    = '0;
      ext_valid   = 1'b0;
      slip_req    = 1'b0;

      tick(3);
      chk("reset_outputs", 64'({fclk, d1, d0, frame_start, ext_ready, underrun}), 64'd0);
      rst_200m = 1'b0;
      tick(2);

      // Fixed 0x2ABC; en rising -> first bit 2 cycles later
      push(same4(14'h2ABC), 1'b0, 0);
      en = 1'b1;
      tick(1);
      chk("latency_c1", 64'(frame_start), 64'd0);
      tick(1);
      chk("latency_c2", 64'(frame_start), 64'd1);
      push(same4(14'h2ABC), 1'b0, 8);
      wait_fs("fixed2");
      push(same4(14'h2ABC), 1'b0, 8);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("fixed_d1_b%0d", b), 64'(d1), 64'({4{d1t[7-b]}}));
         chk($sformatf("fixed_d0_b%0d", b), 64'(d0), 64'({4{d0t[7-b]}}));
         if (b < 7) tick(1);
      end

      // Reset mid-frame at bit 3
      wait_fs("fixed3");
      tick(3);
      rst_200m = 1'b1;
      #1;
      chk("async_reset", 64'({fclk, d1, d0, frame_start}), 64'd0);
      q.delete();
      tick(2);
      rst_200m = 1'b0;
      push(same4(14'h2ABC), 1'b0, 0);
      tick(1);
      chk("post_reset_c1", 64'(frame_start), 64'd0);
      tick(1);
      chk("post_reset_c2", 64'(frame_start), 64'd1);
      en = 1'b0;
      tick(12);

      // Ramp across the 14-bit wrap
      force dut.r_ramp = 14'h3FFE;
      tick(1);
      release dut.r_ramp;
      pattern_sel = 2'd0;
      push(ramp4(14'h3FFE), 1'b0, 0);
      en = 1'b1;
      wait_fs("ramp0");
      push(ramp4(14'h3FFF), 1'b0, 8);
      wait_fs("ramp1");
      push(ramp4(14'h0000), 1'b0, 8);
      wait_fs("ramp2");
      // en dropped at bit 2: frame completes, then IDLE
      tick(2);
      en = 1'b0;
      tick(12);
      push(ramp4(14'h0001), 1'b0, 0);
      en = 1'b1;
      wait_fs("ramp_resume");

      // Checkerboard plus a double slip request within one frame
      pattern_sel = 2'd2;
      push(same4(14'h2AAA), 1'b0, 8);
      wait_fs("chk0");
      push(same4(14'h1555), 1'b0, 9);
      tick(1);
      slip_req = 1'b1;
      tick(1);
      slip_req = 1'b0;
      tick(1);
      slip_req = 1'b1;
      tick(1);
      slip_req = 1'b0;
      wait_fs("chk1");
      push(same4(14'h2AAA), 1'b0, 8);
      wait_fs("chk2");

      // External stream with one underrun
      pattern_sel = 2'd3;
      ext_data = ext_a;
      ext_valid = 1'b1;
      push(ext_a, 1'b1, 8);
      chk("underrun_clear", 64'(underrun), 64'd0);
      wait_fs("ext_a");
      ext_data = ext_b;
      ext_valid = 1'b0;
      push(ext_a, 1'b0, 8);
      wait_fs("ext_repeat");
      chk("underrun_set", 64'(underrun), 64'd1);
      ext_data = ext_c;
      ext_valid = 1'b1;
      push(ext_c, 1'b1, 8);
      wait_fs("ext_c");
      ext_valid = 1'b0;
      en = 1'b0;
      tick(14);
      chk("underrun_sticky", 64'(underrun), 64'd1);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
